// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags with a committed head for one-cycle flush rollback.
// Optional same-cycle release-to-alloc bypass when empty: define FREE_LIST_BYPASS_EN.
module phys_reg_free_list #(
    parameter int unsigned NUM_PHYS_REGS = 64,
    parameter int unsigned NUM_ARCH_REGS = 32,
    localparam int unsigned DEPTH  = NUM_PHYS_REGS - NUM_ARCH_REGS,
    localparam int unsigned PREG_W = $clog2(NUM_PHYS_REGS),
    localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              alloc_req,
    output logic              alloc_valid,
    output logic [PREG_W-1:0] alloc_preg,
    input  logic              release_valid,
    input  logic [PREG_W-1:0] release_preg,
    input  logic              commit_valid,
    output logic              free_list_empty,
    output logic              free_list_full,
    output logic [PTR_W:0]    free_count
);

    logic [PREG_W-1:0] mem_q [DEPTH];

    // Pointers carry an extra wrap bit so full and empty differ only in the MSB.
    logic [PTR_W:0] head_q, head_d;
    logic [PTR_W:0] commit_head_q, commit_head_d;
    logic [PTR_W:0] tail_q, tail_d;

    logic [PTR_W:0] count;
    logic           release_accept;
    logic           alloc_fire;
    logic           bypass;

    assign count           = tail_q - head_q;
    assign free_list_empty = (count == '0);
    assign free_list_full  = (count == (PTR_W+1)'(DEPTH));
    assign free_count      = count;
    assign release_accept  = release_valid && !free_list_full;

`ifdef FREE_LIST_BYPASS_EN
    assign bypass = free_list_empty && release_valid && !flush;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        alloc_valid = !free_list_empty && !flush;
        alloc_preg  = mem_q[head_q[PTR_W-1:0]];
        if (bypass) begin
            alloc_valid = 1'b1;
            alloc_preg  = release_preg;
        end
    end

    assign alloc_fire = alloc_req && alloc_valid;

    always_comb begin
        commit_head_d = commit_head_q + {{PTR_W{1'b0}}, commit_valid};
        tail_d        = tail_q + {{PTR_W{1'b0}}, release_accept};
        head_d        = head_q;
        // Flush discards every speculative allocation beyond the committed point.
        if (flush) begin
            head_d = commit_head_d;
        end else if (alloc_fire) begin
            head_d = head_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q        <= '0;
            commit_head_q <= '0;
            tail_q        <= (PTR_W+1)'(DEPTH);
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= PREG_W'(NUM_ARCH_REGS + i);
            end
        end else begin
            head_q        <= head_d;
            commit_head_q <= commit_head_d;
            tail_q        <= tail_d;
            if (release_accept) begin
                mem_q[tail_q[PTR_W-1:0]] <= release_preg;
            end
        end
    end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed self-checking bench for phys_reg_free_list (64 pregs, 32 arch regs, depth 32).
module tb_phys_reg_free_list;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       alloc_req;
    logic       alloc_valid;
    logic [5:0] alloc_preg;
    logic       release_valid;
    logic [5:0] release_preg;
    logic       commit_valid;
    logic       free_list_empty;
    logic       free_list_full;
    logic [5:0] free_count;

    int n_cmp = 0;
    int n_err = 0;

    phys_reg_free_list #(
        .NUM_PHYS_REGS(64),
        .NUM_ARCH_REGS(32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .alloc_req      (alloc_req),
        .alloc_valid    (alloc_valid),
        .alloc_preg     (alloc_preg),
        .release_valid  (release_valid),
        .release_preg   (release_preg),
        .commit_valid   (commit_valid),
        .free_list_empty(free_list_empty),
        .free_list_full (free_list_full),
        .free_count     (free_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        flush = 0; alloc_req = 0; release_valid = 0; release_preg = '0; commit_valid = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
        #1;
    endtask

    // Allocate n pregs expecting the consecutive sequence starting at first.
    task automatic alloc_seq(input string tag, input int first, input int n);
        for (int i = 0; i < n; i++) begin
            alloc_req = 1;
            #1;
            chk({tag, "_valid"}, 32'(alloc_valid), 1);
            chk({tag, "_preg"}, 32'(alloc_preg), 32'(first + i));
            tick();
        end
        alloc_req = 0;
        #1;
    endtask

    initial begin
        idle();
        do_reset();

        // Reset state
        chk("rst_count", 32'(free_count), 32);
        chk("rst_full", 32'(free_list_full), 1);
        chk("rst_empty", 32'(free_list_empty), 0);
        chk("rst_valid", 32'(alloc_valid), 1);
        chk("rst_preg", 32'(alloc_preg), 32);

        // Full protection: release while full is dropped
        release_valid = 1; release_preg = 6'd3;
        tick();
        idle();
        #1;
        chk("fullprot_count", 32'(free_count), 32);
        chk("fullprot_preg", 32'(alloc_preg), 32);

        // First three grants after reset
        alloc_seq("first3", 32, 3);
        chk("first3_count", 32'(free_count), 29);
        chk("first3_full", 32'(free_list_full), 0);

        // Drain the rest; ring slot 0 must still hold 32, not 3
        do_reset();
        alloc_seq("drain", 32, 32);
        chk("drain_empty", 32'(free_list_empty), 1);
        chk("drain_valid", 32'(alloc_valid), 0);
        chk("drain_count", 32'(free_count), 0);
        alloc_req = 1;
        tick();
        alloc_req = 0;
        #1;
        chk("over_count", 32'(free_count), 0);
        chk("over_empty", 32'(free_list_empty), 1);

        // Refill after wrap
        release_valid = 1; release_preg = 6'd5;  tick();
        release_preg = 6'd9;  tick();
        release_preg = 6'd12; tick();
        idle();
        #1;
        chk("refill_count", 32'(free_count), 3);
        alloc_req = 1; #1; chk("refill_g0", 32'(alloc_preg), 5);  tick();
        #1; chk("refill_g1", 32'(alloc_preg), 9);  tick();
        #1; chk("refill_g2", 32'(alloc_preg), 12); tick();
        alloc_req = 0;
        #1;
        chk("refill_empty", 32'(free_list_empty), 1);

        // Release into empty with alloc_req
        release_valid = 1; release_preg = 6'd17; alloc_req = 1;
        #1;
`ifdef FREE_LIST_BYPASS_EN
        chk("byp_valid", 32'(alloc_valid), 1);
        chk("byp_preg", 32'(alloc_preg), 17);
        tick();
        idle();
        #1;
        chk("byp_count", 32'(free_count), 0);
`else
        chk("byp_valid", 32'(alloc_valid), 0);
        tick();
        idle();
        #1;
        chk("byp_count", 32'(free_count), 1);
        alloc_seq("byp_late", 17, 1);
        chk("byp_late_empty", 32'(free_list_empty), 1);
`endif

        // Flush rollback to committed head
        do_reset();
        alloc_seq("fl_alloc", 32, 4);
        commit_valid = 1; tick(); tick(); commit_valid = 0;
        flush = 1; alloc_req = 1;
        #1;
        chk("fl_valid_in_flush", 32'(alloc_valid), 0);
        tick();
        idle();
        #1;
        chk("fl_preg", 32'(alloc_preg), 34);
        chk("fl_count", 32'(free_count), 30);

        // Flush with a same-cycle commit rolls back to commit_head+1
        alloc_seq("flc_alloc", 34, 2);
        flush = 1; commit_valid = 1;
        tick();
        idle();
        #1;
        chk("flc_preg", 32'(alloc_preg), 35);
        chk("flc_count", 32'(free_count), 29);

        // Flush together with a release
        do_reset();
        alloc_seq("flr_alloc", 32, 4);
        commit_valid = 1; tick(); tick(); commit_valid = 0;
        flush = 1; release_valid = 1; release_preg = 6'd7;
        tick();
        idle();
        #1;
        chk("flr_count", 32'(free_count), 31);
        alloc_seq("flr_drain", 34, 30);
        alloc_seq("flr_seven", 7, 1);
        chk("flr_empty", 32'(free_list_empty), 1);

        // Simultaneous alloc and release keeps the count
        do_reset();
        alloc_seq("sim_pre", 32, 1);
        alloc_req = 1; release_valid = 1; release_preg = 6'd40;
        #1;
        chk("sim_preg", 32'(alloc_preg), 33);
        tick();
        idle();
        #1;
        chk("sim_count", 32'(free_count), 31);
        chk("sim_next", 32'(alloc_preg), 34);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
